rx_bit_timer: RTL and testbench

Parametrised bit-timing and byte-framing block for the USB receive path. It recovers the bit clock from oversampled line edges and emits one `shift_enable` strobe per bit at a programmable sample phase. It counts data bits while skipping bit-stuffed bits, pulses `byte_received` at each byte boundary, and flags run-length (stuff) violations. It sits between the edge detector and the NRZI decoder / shift register, and replaces the fixed 8x / 8-bit receiver timer.

---
 rtl/rx_bit_timer.sv | 81 ++++++++
 tb/tb_rx_bit_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_timer.sv
// Receive bit timer: recovers the bit clock from oversampled line edges,
// strobes shift_enable once per bit, frames bytes and flags stuff violations.
module rx_bit_timer #(
  parameter int OSR           = 8,
  parameter int SAMPLE_PHASE  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int MAX_RUN       = 6
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 rcving,
  input  logic                                 d_edge,
  input  logic                                 stuff_bit,
  output logic                                 shift_enable,
  output logic                                 byte_received,
  output logic [$clog2(BITS_PER_BYTE+1)-1:0]   bit_cnt,
  output logic                                 run_err
);

  localparam int PH_W  = $clog2(OSR);
  localparam int CNT_W = $clog2(BITS_PER_BYTE + 1);
  localparam int RUN_W = $clog2(MAX_RUN + 2);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(SAMPLE_PHASE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BITS_PER_BYTE - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_RUN + 1);

  logic [PH_W-1:0]  ph;
  logic [RUN_W-1:0] run_cnt;
  logic             count_bit;
  logic             last_bit;

  // Moore strobe from the registered phase, so an edge in this cycle never cancels it
  assign shift_enable = rcving && (ph == PH_SAMPLE);
  assign count_bit    = shift_enable && !stuff_bit;
  assign last_bit     = count_bit && (bit_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!n_rst || !rcving) begin
      ph <= '0;
    end else if (d_edge || ph == PH_LAST) begin
      ph <= '0;
    end else begin
      ph <= ph + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || !rcving) begin
      bit_cnt       <= '0;
      byte_received <= 1'b0;
    end else begin
      byte_received <= last_bit;
      if (last_bit) begin
        bit_cnt <= '0;
      end else if (count_bit) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Saturating count of samples since the last edge; the error is sticky per packet
  always_ff @(posedge clk) begin
    if (!n_rst || !rcving) begin
      run_cnt <= '0;
      run_err <= 1'b0;
    end else begin
      if (shift_enable && run_cnt == RUN_LIMIT) begin
        run_err <= 1'b1;
      end
      if (d_edge) begin
        run_cnt <= '0;
      end else if (shift_enable && run_cnt != RUN_SAT) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: two instances (default and OSR=4/SP=1/16-bit
// bytes) driven with directed packets; expected strobe cycles are queued up front.
module tb_rx_bit_timer;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk;
  logic n_rst;
  logic rcv [2];
  logic edg [2];
  logic stf [2];

  logic       se0, se1, br0, br1, re0, re1;
  logic [3:0] bc0;
  logic [4:0] bc1;

  logic se_v [2];
  logic br_v [2];
  logic re_v [2];
  int   bc_v [2];

  int osrv [2] = '{8, 4};
  int spv  [2] = '{3, 1};
  int bpbv [2] = '{8, 16};

  exp_t shq [2][$];
  int   brq [2][$];

  int cyc    = 0;
  int total  = 0;
  int passed = 0;

  rx_bit_timer u_dut0 (
    .clk(clk), .n_rst(n_rst), .rcving(rcv[0]), .d_edge(edg[0]), .stuff_bit(stf[0]),
    .shift_enable(se0), .byte_received(br0), .bit_cnt(bc0), .run_err(re0)
  );

  rx_bit_timer #(.OSR(4), .SAMPLE_PHASE(1), .BITS_PER_BYTE(16), .MAX_RUN(6)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .rcving(rcv[1]), .d_edge(edg[1]), .stuff_bit(stf[1]),
    .shift_enable(se1), .byte_received(br1), .bit_cnt(bc1), .run_err(re1)
  );

  always_comb begin
    se_v[0] = se0; se_v[1] = se1;
    br_v[0] = br0; br_v[1] = br1;
    re_v[0] = re0; re_v[1] = re1;
    bc_v[0] = int'(bc0); bc_v[1] = int'(bc1);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(string name, int act, int expv);
    total++;
    if (act == expv) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endfunction

  // Monitor: every strobe the DUT presents must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    int   b;
    if (n_rst) begin
      for (int d = 0; d < 2; d++) begin
        if (se_v[d] === 1'b1) begin
          if (shq[d].size() == 0) begin
            checkOutput($sformatf("dut%0d_shift_unexpected", d), cyc, -1);
          end else begin
            e = shq[d].pop_front();
            checkOutput($sformatf("dut%0d_shift_cycle", d), cyc, e.cyc);
            checkOutput($sformatf("dut%0d_shift_bit_cnt", d), bc_v[d], e.cnt);
          end
        end
        if (br_v[d] === 1'b1) begin
          if (brq[d].size() == 0) begin
            checkOutput($sformatf("dut%0d_byte_unexpected", d), cyc, -1);
          end else begin
            b = brq[d].pop_front();
            checkOutput($sformatf("dut%0d_byte_cycle", d), cyc, b);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void pushShift(int d, int c, int cnt);
    exp_t e;
    e.cyc = c;
    e.cnt = cnt;
    shq[d].push_back(e);
  endfunction

  // Queue n shifts spaced one bit apart, with byte pulses at the wrap points
  function automatic void expectRun(int d, int first, int n, int start_cnt);
    int cnt;
    for (int k = 0; k < n; k++) begin
      cnt = (start_cnt + k) % bpbv[d];
      pushShift(d, first + k * osrv[d], cnt);
      if (cnt == bpbv[d] - 1) brq[d].push_back(first + k * osrv[d] + 1);
    end
  endfunction

  task automatic applyStimulus(int d, int until_cyc, int stuff_cyc, int edge_cyc);
    while (cyc < until_cyc) begin
      tick();
      stf[d] = (cyc == stuff_cyc);
      edg[d] = (cyc == edge_cyc);
    end
  endtask

  task automatic startPacket(int d, output int c);
    tick();
    c = cyc;
    rcv[d] = 1'b1;
    edg[d] = 1'b1;
    stf[d] = 1'b0;
  endtask

  task automatic endPacket(int d, string tag);
    rcv[d] = 1'b0;
    edg[d] = 1'b0;
    stf[d] = 1'b0;
    repeat (2 * osrv[d]) tick();
    checkOutput($sformatf("dut%0d_%s_shifts_left", d, tag), shq[d].size(), 0);
    checkOutput($sformatf("dut%0d_%s_bytes_left", d, tag), brq[d].size(), 0);
    checkOutput($sformatf("dut%0d_%s_idle_bit_cnt", d, tag), bc_v[d], 0);
    checkOutput($sformatf("dut%0d_%s_idle_run_err", d, tag), int'(re_v[d]), 0);
    shq[d].delete();
    brq[d].delete();
  endtask

  task automatic freeRun(int d);
    int c, s0, last;
    startPacket(d, c);
    s0   = c + 1 + spv[d];
    last = s0 + (bpbv[d] - 1) * osrv[d];
    expectRun(d, s0, bpbv[d], 0);
    applyStimulus(d, last + 1, -1, -1);
    checkOutput($sformatf("dut%0d_free_wrap_bit_cnt", d), bc_v[d], 0);
    endPacket(d, "free");
  endtask

  task automatic stuffTest(int d);
    int c, s0, last;
    startPacket(d, c);
    s0   = c + 1 + spv[d];
    last = s0 + bpbv[d] * osrv[d];
    for (int k = 0; k <= bpbv[d]; k++) pushShift(d, s0 + k * osrv[d], (k <= 3) ? k : k - 1);
    brq[d].push_back(last + 1);
    applyStimulus(d, last + 1, s0 + 3 * osrv[d], -1);
    endPacket(d, "stuff");
  endtask

  // Resync mid-bit, then drop rcving after 5 counted bits
  task automatic resyncAbort(int d);
    int c, s0, e;
    startPacket(d, c);
    s0 = c + 1 + spv[d];
    e  = c + 1 + osrv[d] + spv[d] + 2;
    pushShift(d, s0, 0);
    pushShift(d, s0 + osrv[d], 1);
    expectRun(d, e + 1 + spv[d], 3, 2);
    applyStimulus(d, e + 1 + spv[d] + 2 * osrv[d] + 1, -1, e);
    checkOutput($sformatf("dut%0d_abort_bit_cnt_before", d), bc_v[d], 5);
    endPacket(d, "abort");
  endtask

  task automatic runErrTest(int d);
    int c, s0, s6;
    startPacket(d, c);
    s0 = c + 1 + spv[d];
    s6 = s0 + 6 * osrv[d];
    expectRun(d, s0, 9, 0);
    applyStimulus(d, s6, -1, -1);
    checkOutput($sformatf("dut%0d_run_err_at_7th", d), int'(re_v[d]), 0);
    applyStimulus(d, s6 + 1, -1, -1);
    checkOutput($sformatf("dut%0d_run_err_after_7th", d), int'(re_v[d]), 1);
    applyStimulus(d, s0 + 8 * osrv[d] + 1, -1, -1);
    checkOutput($sformatf("dut%0d_run_err_sticky", d), int'(re_v[d]), 1);
    endPacket(d, "runerr");
  endtask

  task automatic noErrTest(int d);
    int c, s0, e;
    startPacket(d, c);
    s0 = c + 1 + spv[d];
    e  = s0 + 5 * osrv[d] + 2;
    expectRun(d, s0, 6, 0);
    expectRun(d, e + 1 + spv[d], 3, 6);
    applyStimulus(d, e + 1 + spv[d] + 2 * osrv[d] + 1, -1, e);
    checkOutput($sformatf("dut%0d_no_run_err", d), int'(re_v[d]), 0);
    endPacket(d, "noerr");
  endtask

  // rcving drops exactly in the cycle of the last data bit's sample
  task automatic lastBitDrop(int d);
    int c, s0;
    startPacket(d, c);
    s0 = c + 1 + spv[d];
    expectRun(d, s0, bpbv[d] - 1, 0);
    applyStimulus(d, s0 + (bpbv[d] - 1) * osrv[d], -1, -1);
    checkOutput($sformatf("dut%0d_drop_bit_cnt_before", d), bc_v[d], bpbv[d] - 1);
    endPacket(d, "lastdrop");
  endtask

  task automatic midReset(int d);
    int c, s0;
    startPacket(d, c);
    s0 = c + 1 + spv[d];
    expectRun(d, s0, 3, 0);
    applyStimulus(d, s0 + 2 * osrv[d] + 1, -1, -1);
    n_rst = 1'b0;
    tick();
    checkOutput($sformatf("dut%0d_midreset_bit_cnt", d), bc_v[d], 0);
    checkOutput($sformatf("dut%0d_midreset_shift", d), int'(se_v[d]), 0);
    rcv[d] = 1'b0;
    n_rst  = 1'b1;
    endPacket(d, "midreset");
  endtask

  initial begin
    #200000;
    checkOutput("watchdog_timeout", 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    n_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rcv[d] = 1'b1;
      edg[d] = 1'b1;
      stf[d] = 1'b0;
    end
    repeat (2) begin
      tick();
      for (int d = 0; d < 2; d++) edg[d] = ~edg[d];
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d_reset_shift", d), int'(se_v[d]), 0);
      checkOutput($sformatf("dut%0d_reset_byte", d), int'(br_v[d]), 0);
      checkOutput($sformatf("dut%0d_reset_bit_cnt", d), bc_v[d], 0);
      checkOutput($sformatf("dut%0d_reset_run_err", d), int'(re_v[d]), 0);
      rcv[d] = 1'b0;
      edg[d] = 1'b0;
    end
    n_rst = 1'b1;
    repeat (3) tick();

    for (int d = 0; d < 2; d++) begin
      $display("[TB] directed tests on dut%0d", d);
      freeRun(d);
      stuffTest(d);
      resyncAbort(d);
      runErrTest(d);
      noErrTest(d);
      lastBitDrop(d);
    end
    midReset(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
